// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data memory arbiter, its two requesters
// (core pointer port and host loader port) and the data SRAM.
interface data_mem_arbiter_if #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 8
);

    // core requester
    logic                 core_req;
    logic                 core_we;
    logic [AddrWidth-1:0] core_addr;
    logic [DataWidth-1:0] core_wdata;
    logic                 core_gnt;
    logic                 core_stall;
    logic                 core_rvalid;
    logic [DataWidth-1:0] core_rdata;

    // loader requester
    logic                 ldr_req;
    logic                 ldr_we;
    logic [AddrWidth-1:0] ldr_addr;
    logic [DataWidth-1:0] ldr_wdata;
    logic                 ldr_gnt;
    logic                 ldr_rvalid;
    logic [DataWidth-1:0] ldr_rdata;

    // memory side
    logic                 mem_en;
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [DataWidth-1:0] mem_wdata;
    logic [DataWidth-1:0] mem_rdata;

    // arbiter view
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // requesters + memory view
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: core has fixed priority, the loader
// is forced through after StarveLimit denied cycles. Reads return in 1 cycle.
module data_mem_arbiter #(
    parameter int AddrWidth   = 8,
    parameter int DataWidth   = 8,
    parameter int StarveLimit = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CORE = 2'd1,
        TAG_LDR  = 2'd2
    } tag_e;

    localparam logic [3:0] Limit = 4'(StarveLimit);

    logic [3:0]           starve_q, starve_d;
    tag_e                 tag_q, tag_d;
    logic                 ldr_win;
    logic                 core_gnt;
    logic                 ldr_gnt;
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [DataWidth-1:0] mem_wdata;
    logic                 core_rvalid;
    logic                 ldr_rvalid;

    // Arbitration: starved loader first, then core, then idle loader.
    // Everything is masked during reset so no access leaks out.
    always_comb begin
        ldr_win  = bus.ldr_req & ((starve_q == Limit) | ~bus.core_req);
        ldr_gnt  = rst_n & ldr_win;
        core_gnt = rst_n & bus.core_req & ~ldr_win;
    end

    // Memory command mux from the granted requester; zero when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            core_gnt: begin
                mem_we    = bus.core_we;
                mem_addr  = bus.core_addr;
                mem_wdata = bus.core_wdata;
            end
            ldr_gnt: begin
                mem_we    = bus.ldr_we;
                mem_addr  = bus.ldr_addr;
                mem_wdata = bus.ldr_wdata;
            end
            default: ;
        endcase
    end

    // Next starvation count and read-owner tag.
    always_comb begin
        starve_d = '0;
        if (bus.ldr_req & ~ldr_gnt) begin
            starve_d = (starve_q == Limit) ? starve_q
                                           : starve_q + 4'd1;
        end
        tag_d = TAG_NONE;
        if (core_gnt & ~bus.core_we) begin
            tag_d = TAG_CORE;
        end else if (ldr_gnt & ~bus.ldr_we) begin
            tag_d = TAG_LDR;
        end
    end

    // State registers; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
            tag_q    <= TAG_NONE;
        end else begin
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

    // Return path: steer mem_rdata to the owner of last cycle's read.
    always_comb begin
        core_rvalid = rst_n & (tag_q == TAG_CORE);
        ldr_rvalid  = rst_n & (tag_q == TAG_LDR);
    end

    assign bus.core_gnt    = core_gnt;
    assign bus.ldr_gnt     = ldr_gnt;
    assign bus.core_stall  = rst_n & bus.core_req & ~core_gnt;
    assign bus.mem_en      = core_gnt | ldr_gnt;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.core_rvalid = core_rvalid;
    assign bus.ldr_rvalid  = ldr_rvalid;
    assign bus.core_rdata  = core_rvalid ? bus.mem_rdata : '0;
    assign bus.ldr_rdata   = ldr_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal checks
// plus a per-cycle comparison against a behavioural model.
module tb_data_mem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    data_mem_arbiter #(
        .AddrWidth  (AW),
        .DataWidth  (DW),
        .StarveLimit(LIM)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // SRAM attached to the arbiter's memory port
    logic [DW-1:0] sram [2**AW];
    logic [DW-1:0] sram_q = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else sram_q <= sram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = sram_q;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] ref_mem [2**AW];
    int            cnt = 0;
    int            pend = 0;
    logic [DW-1:0] pend_data = '0;
    logic          m_cg = 1'b0;
    logic          m_lg = 1'b0;

    // Per-cycle compare, outputs settled mid-cycle
    always @(negedge clk) begin
        logic          e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        m_cg = 1'b0; m_lg = 1'b0;
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (rst_n) begin
            m_lg = bus.ldr_req && (cnt == LIM || !bus.core_req);
            m_cg = bus.core_req && !m_lg;
        end
        if (m_cg) begin
            e_we = bus.core_we; e_addr = bus.core_addr; e_wd = bus.core_wdata;
        end else if (m_lg) begin
            e_we = bus.ldr_we; e_addr = bus.ldr_addr; e_wd = bus.ldr_wdata;
        end
        e_en = m_cg || m_lg;
        chk("core_gnt", bus.core_gnt, m_cg);
        chk("ldr_gnt", bus.ldr_gnt, m_lg);
        chk("core_stall", bus.core_stall, rst_n && bus.core_req && !m_cg);
        chk("mem_en", bus.mem_en, e_en);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wd);
        chk("core_rvalid", bus.core_rvalid, rst_n && pend == 1);
        chk("ldr_rvalid", bus.ldr_rvalid, rst_n && pend == 2);
        chk("core_rdata", bus.core_rdata,
            (rst_n && pend == 1) ? pend_data : '0);
        chk("ldr_rdata", bus.ldr_rdata,
            (rst_n && pend == 2) ? pend_data : '0);
    end

    // Model state advance on the clock edge
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt  = 0;
            pend = 0;
        end else begin
            if (bus.ldr_req && !m_lg) cnt = (cnt < LIM) ? cnt + 1 : LIM;
            else cnt = 0;
            pend = 0;
            if (m_cg) begin
                if (bus.core_we) ref_mem[bus.core_addr] = bus.core_wdata;
                else begin pend = 1; pend_data = ref_mem[bus.core_addr]; end
            end else if (m_lg) begin
                if (bus.ldr_we) ref_mem[bus.ldr_addr] = bus.ldr_wdata;
                else begin pend = 2; pend_data = ref_mem[bus.ldr_addr]; end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r,
                       input logic cr, input logic cw,
                       input logic [7:0] ca, input logic [7:0] cd,
                       input logic lr, input logic lw,
                       input logic [7:0] la, input logic [7:0] ld);
        @(posedge clk); #1;
        rst_n = r;
        bus.core_req = cr; bus.core_we = cw;
        bus.core_addr = ca; bus.core_wdata = cd;
        bus.ldr_req = lr; bus.ldr_we = lw;
        bus.ldr_addr = la; bus.ldr_wdata = ld;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            sram[i] = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        sram[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
        sram[8'h01] = 8'h11; ref_mem[8'h01] = 8'h11;
        sram[8'h02] = 8'h22; ref_mem[8'h02] = 8'h22;
        sram[8'h03] = 8'h33; ref_mem[8'h03] = 8'h33;
        bus.core_req = 0; bus.core_we = 0;
        bus.core_addr = 0; bus.core_wdata = 0;
        bus.ldr_req = 0; bus.ldr_we = 0;
        bus.ldr_addr = 0; bus.ldr_wdata = 0;

        // reset with requests pending
        cyc(0, 1, 1, 8'h44, 8'h99, 1, 0, 8'h45, 0);
        chk("rst_core_gnt", bus.core_gnt, 0);
        chk("rst_ldr_gnt", bus.ldr_gnt, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_stall", bus.core_stall, 0);

        // reset mid-read
        cyc(1, 1, 0, 8'h10, 0, 0, 0, 0, 0);
        chk("mr_gnt", bus.core_gnt, 1);
        cyc(0, 1, 0, 8'h10, 0, 0, 0, 0, 0);
        chk("mr_rst_rvalid", bus.core_rvalid, 0);
        chk("mr_rst_mem_en", bus.mem_en, 0);
        idle();
        chk("mr_no_rvalid", bus.core_rvalid, 0);

        // core-only read
        cyc(1, 1, 0, 8'h10, 0, 0, 0, 0, 0);
        chk("cr_gnt", bus.core_gnt, 1);
        chk("cr_addr", bus.mem_addr, 8'h10);
        idle();
        chk("cr_rvalid", bus.core_rvalid, 1);
        chk("cr_rdata", bus.core_rdata, 8'h5A);
        chk("cr_ldr_rvalid", bus.ldr_rvalid, 0);

        // contention: loader forced in on the 5th cycle
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
            chk("ct_core_gnt", bus.core_gnt, 1);
            chk("ct_ldr_gnt", bus.ldr_gnt, 0);
        end
        cyc(1, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        chk("ct_force_ldr", bus.ldr_gnt, 1);
        chk("ct_stall", bus.core_stall, 1);
        chk("ct_force_addr", bus.mem_addr, 8'h02);
        cyc(1, 1, 0, 8'h01, 0, 0, 0, 0, 0);
        chk("ct_core_back", bus.core_gnt, 1);
        chk("ct_ldr_rvalid", bus.ldr_rvalid, 1);
        chk("ct_ldr_rdata", bus.ldr_rdata, 8'h22);
        idle();
        chk("ct_core_rdata", bus.core_rdata, 8'h11);

        // loader write, then core read of the same address
        cyc(1, 0, 0, 0, 0, 1, 1, 8'h20, 8'hA5);
        chk("rw_mem_we", bus.mem_we, 1);
        chk("rw_wdata", bus.mem_wdata, 8'hA5);
        cyc(1, 1, 0, 8'h20, 0, 0, 0, 0, 0);
        chk("rw_no_ldr_rv", bus.ldr_rvalid, 0);
        idle();
        chk("rw_rvalid", bus.core_rvalid, 1);
        chk("rw_rdata", bus.core_rdata, 8'hA5);
        chk("rw_ldr_rv", bus.ldr_rvalid, 0);

        // back-to-back core reads
        cyc(1, 1, 0, 8'h01, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 8'h02, 0, 0, 0, 0, 0);
        chk("bb_d1", bus.core_rdata, 8'h11);
        cyc(1, 1, 0, 8'h03, 0, 0, 0, 0, 0);
        chk("bb_d2", bus.core_rdata, 8'h22);
        idle();
        chk("bb_d3", bus.core_rdata, 8'h33);

        // loader drops its request: counter must restart from zero
        cyc(1, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        chk("dr_ldr_gnt0", bus.ldr_gnt, 0);
        cyc(1, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        chk("dr_ldr_gnt1", bus.ldr_gnt, 0);
        cyc(1, 1, 0, 8'h01, 0, 0, 0, 0, 0);
        chk("dr_no_stall", bus.core_stall, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 8'h01, 0, 1, 0, 8'h03, 0);
            chk("dr_wait", bus.ldr_gnt, 0);
        end
        cyc(1, 1, 0, 8'h01, 0, 1, 0, 8'h03, 0);
        chk("dr_forced", bus.ldr_gnt, 1);
        idle();

        // mixed traffic, requests held until granted
        for (int i = 0; i < 400; i++) begin
            logic r, cr, cw, lr, lw;
            logic [7:0] ca, cd, la, ld;
            r = ($urandom_range(0, 99) != 0);
            cr = bus.core_req; cw = bus.core_we;
            ca = bus.core_addr; cd = bus.core_wdata;
            lr = bus.ldr_req; lw = bus.ldr_we;
            la = bus.ldr_addr; ld = bus.ldr_wdata;
            if (!cr || m_cg || $urandom_range(0, 19) == 0) begin
                cr = ($urandom_range(0, 2) != 0);
                cw = $urandom_range(0, 1) == 1;
                ca = 8'($urandom_range(0, 15));
                cd = 8'($urandom);
            end
            if (!lr || m_lg || $urandom_range(0, 19) == 0) begin
                lr = ($urandom_range(0, 1) != 0);
                lw = $urandom_range(0, 1) == 1;
                la = 8'($urandom_range(0, 15));
                ld = 8'($urandom);
            end
            cyc(r, cr, cw, ca, cd, lr, lw, la, ld);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
